load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the RV32I ALU.
- Takes the ALU result as the effective address and the rs2 value as store data.
- Performs byte-lane steering, alignment checking and sign/zero extension.
- Runs a req/ack handshake with data memory and holds the pipeline stalled until the access completes, faults or times out.

Parameters:
- TIMEOUT, 16: max cycles waiting for dmem_ack before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  EX stage presents an instruction
- ex_mem_read  in  1  load instruction
- ex_mem_write  in  1  store instruction
- ex_funct3  in  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- ex_addr  in  32  effective address (alu_result)
- ex_wdata  in  32  store data (rs2)
- lsu_busy  out  1  stall request to the pipeline
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  32  extended load data, valid with lsu_done
- lsu_misaligned  out  1  alignment/encoding fault, valid with lsu_done
- lsu_bus_err  out  1  timeout or read+write conflict, valid with lsu_done
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address, bits [1:0] always 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  memory completion

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset state: state=IDLE, timeout counter=0. Every output is 0, including lsu_busy.
- Reset mid-access: dmem_req drops at the reset edge and no lsu_done is issued.
- States: IDLE, REQ, DONE.
- Accept condition: in IDLE with ex_valid & (ex_mem_read | ex_mem_write). At acceptance, addr, funct3, data and direction are registered.
- lsu_busy = (state != IDLE) | accept. It is combinational, so the stall applies in the accept cycle. It is still high in DONE and low once back in IDLE.
- Alignment rules, checked at accept:
  - funct3[1:0]=00: any address.
  - funct3[1:0]=01: requires addr[0]=0.
  - funct3[1:0]=10: requires addr[1:0]=00.
  - funct3[1:0]=11: illegal.
  - A store with funct3[2]=1 is illegal.
- Fault at accept: a fault goes IDLE->DONE with lsu_misaligned=1 and no dmem_req.
- Read+write conflict: ex_mem_read and ex_mem_write both high goes IDLE->DONE with lsu_bus_err=1 and no request. The conflict takes priority over misalignment.
- Clean accept: IDLE->REQ.
- REQ outputs: dmem_req=1, and dmem_we/addr/be/wdata hold constant until exit.
- REQ exit on dmem_ack=1:
  - For a load, lsu_rdata is captured from dmem_rdata.
  - Next state is DONE, and dmem_req falls on the following cycle.
  - Minimum latency: accept at N, req at N+1, ack at N+1, done pulse at N+2.
- REQ timeout: the counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 with no ack, the FSM goes to DONE with lsu_bus_err=1, and a later ack is ignored. The counter clears on REQ entry.
- DONE: lsu_done=1 for exactly one cycle, then IDLE. The flags and lsu_rdata are held only during DONE and are 0 otherwise.
- lsu_rdata is 0 for stores and faults.
- dmem_ack outside REQ is ignored.
- Throughput: at most one access per 3 cycles.
- Store lanes:
  - SB: wdata={4{b}}, be=0001<<addr[1:0].
  - SH: wdata={2{h}}, be=0011 (addr[1]=0) or 1100.
  - SW: be=1111.
- Load lanes:
  - dmem_be is the same pattern as for stores.
  - dmem_wdata=0.
  - Data is rdata>>(8*addr[1:0]), then sign- or zero-extended per funct3[2].

Decomposition:
- Shared header/package lsu_defs holds:
  - funct3 load/store encodings (LB/LH/LW/LBU/LHU/SB/SH/SW)
  - state encodings IDLE/REQ/DONE
  - lane-mask constants
- One natural combinational sub-module, lsu_align:
  - inputs: funct3, addr[1:0], wdata, rdata
  - outputs: be, steered wdata, extended rdata, misaligned
- FSM, counter and registers stay in load_store_unit.

Test Plan:
- SB with ex_addr=0x1003, ex_wdata=0xAABBCCDD, ack on first REQ cycle -> dmem_addr=0x1000, be=1000, wdata=0xDDDDDDDD, lsu_done at N+2.
- LB at addr 0x2001, rdata=0x1234_80FF -> lsu_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH at 0x3001 -> lsu_misaligned=1, lsu_done at N+1, dmem_req never asserted. LW at 0x3002 -> same response.
- LW with TIMEOUT=4 and ack never asserted -> dmem_req high for 4 cycles, then lsu_bus_err=1 with lsu_done. A late ack is ignored.
- LHU at 0x4002, rdata=0xBEEF0000, ack delayed 5 cycles -> lsu_busy high throughout, dmem outputs stable, lsu_rdata=0x0000BEEF.
- rst_n=0 during REQ -> all outputs 0 at the next edge, no lsu_done. A following SW at 0x10 with wdata=0x12345678 completes normally with be=1111.

Source files
------------

// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: states, funct3 encodings, lane masks.
package lsu_defs;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } ld_funct3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } st_funct3_e;

    // Access size lives in funct3[1:0].
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Access captured at acceptance and held for the whole transaction.
    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [3:0]      be;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, alignment check and load extension (purely combinational).
module lsu_align
    import lsu_defs::*;
(
    input  logic [2:0]      funct3,
    input  logic            is_store,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    logic [1:0]      size;
    logic [XLEN-1:0] shifted;

    assign size    = funct3[1:0];
    assign shifted = rdata >> {addr_lo, 3'b000};

    // Lane mask, replicated store data, extended load data and legality per size.
    always_comb begin
        be         = '0;
        wdata_lane = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                be         = BE_BYTE << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = funct3[2] ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            SZ_W: begin
                be         = BE_WORD;
                wdata_lane = wdata;
                rdata_ext  = shifted;
                misaligned = (addr_lo != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (is_store && funct3[2]) begin
            misaligned = 1'b1;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: accepts one load/store, runs the dmem req/ack handshake.
module load_store_unit
    import lsu_defs::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    output logic            lsu_busy,
    output logic            lsu_done,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_misaligned,
    output logic            lsu_bus_err,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    lsu_state_e      state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            mis_q, mis_d;
    logic            berr_q, berr_d;

    logic            accept;
    logic            conflict;
    logic            timeout_hit;
    logic            in_idle;
    logic            in_req;
    logic            in_done;

    logic [2:0]      al_funct3;
    logic            al_store;
    logic [1:0]      al_addr_lo;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_mis;

    assign in_idle     = (state_q == ST_IDLE);
    assign in_req      = (state_q == ST_REQ);
    assign in_done     = (state_q == ST_DONE);
    assign accept      = rst_n & in_idle & ex_valid & (ex_mem_read | ex_mem_write);
    assign conflict    = ex_mem_read & ex_mem_write;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(LAST));

    // The aligner sees the incoming access while idle and the held access otherwise.
    assign al_funct3  = in_idle ? ex_funct3    : req_q.funct3;
    assign al_store   = in_idle ? ex_mem_write : req_q.we;
    assign al_addr_lo = in_idle ? ex_addr[1:0] : req_q.addr[1:0];

    lsu_align u_align (
        .funct3     (al_funct3),
        .is_store   (al_store),
        .addr_lo    (al_addr_lo),
        .wdata      (ex_wdata),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_mis)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // Next-state logic: accept/fault in IDLE, wait for ack or timeout in REQ, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        berr_d  = berr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d.we     = ex_mem_write;
                    req_d.funct3 = ex_funct3;
                    req_d.addr   = ex_addr;
                    req_d.be     = al_be;
                    req_d.wdata  = ex_mem_write ? al_wdata : '0;
                    cnt_d        = '0;
                    rdata_d      = '0;
                    mis_d        = 1'b0;
                    berr_d       = 1'b0;
                    if (conflict) begin
                        berr_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (al_mis) begin
                        mis_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    if (!req_q.we) begin
                        rdata_d = al_rdata;
                    end
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    berr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                rdata_d = '0;
                mis_d   = 1'b0;
                berr_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from registered state; everything is zero outside its owning state.
    assign lsu_busy       = ~in_idle | accept;
    assign lsu_done       = in_done;
    assign lsu_rdata      = in_done ? rdata_q : '0;
    assign lsu_misaligned = in_done & mis_q;
    assign lsu_bus_err    = in_done & berr_q;
    assign dmem_req       = in_req;
    assign dmem_we        = in_req & req_q.we;
    assign dmem_addr      = in_req ? {req_q.addr[XLEN-1:2], 2'b00} : '0;
    assign dmem_be        = in_req ? req_q.be : '0;
    assign dmem_wdata     = in_req ? req_q.wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus timeout and reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_valid_t, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata, dmem_rdata;
    logic        dmem_ack;

    logic        lsu_busy, lsu_done, lsu_misaligned, lsu_bus_err;
    logic [31:0] lsu_rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;

    logic        t_busy, t_done, t_mis, t_berr;
    logic [31:0] t_rdata;
    logic        t_req, t_we;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_misaligned(lsu_misaligned), .lsu_bus_err(lsu_bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    load_store_unit #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid_t),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_busy(t_busy), .lsu_done(t_done), .lsu_rdata(t_rdata),
        .lsu_misaligned(t_mis), .lsu_bus_err(t_berr),
        .dmem_req(t_req), .dmem_we(t_we), .dmem_addr(t_addr),
        .dmem_be(t_be), .dmem_wdata(t_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        logic [31:0] e_daddr;
        logic [3:0]  e_be;
        logic [31:0] e_dwdata;
        logic [31:0] e_rdata;
        logic        e_mis;
        logic        e_berr;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ack_dly,
                                input logic [31:0] e_daddr, input logic [3:0] e_be,
                                input logic [31:0] e_dwdata, input logic [31:0] e_rdata,
                                input logic e_mis, input logic e_berr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.ack_dly = ack_dly; v.e_daddr = e_daddr; v.e_be = e_be;
        v.e_dwdata = e_dwdata; v.e_rdata = e_rdata; v.e_mis = e_mis; v.e_berr = e_berr;
        return v;
    endfunction

    task automatic check_zero_main(input string tag);
        chk({tag, "_ctl"}, {25'b0, lsu_busy, lsu_done, lsu_misaligned, lsu_bus_err,
                            dmem_req, dmem_we, 1'b0} | {28'b0, dmem_be}, 32'h0);
        chk({tag, "_rdata"}, lsu_rdata, 32'h0);
        chk({tag, "_daddr"}, dmem_addr, 32'h0);
        chk({tag, "_dwdata"}, dmem_wdata, 32'h0);
    endtask

    // Issue one access to the main DUT and follow it to completion.
    task automatic run_vec(input int id, input vec_t v);
        int  k;
        int  reqs;
        bit  done;
        bit  exp_req;
        int  exp_k;
        exp_req = !(v.e_mis || v.e_berr);
        exp_k   = exp_req ? v.ack_dly + 2 : 1;
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = v.rd; ex_mem_write = v.wr;
        ex_funct3 = v.f3; ex_addr = v.addr; ex_wdata = v.wdata;
        #1;
        chk($sformatf("v%0d_busy_accept", id), lsu_busy, 1);
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_wdata = 32'hFFFF_FFFF; ex_addr = 32'hFFFF_FFFF;
        k = 1; reqs = 0; done = 1'b0;
        while (!done && k <= 40) begin
            dmem_ack = 1'b0;
            dmem_rdata = 32'h5A5A_5A5A;
            if (lsu_done) begin
                done = 1'b1;
            end else begin
                chk($sformatf("v%0d_busy_k%0d", id, k), lsu_busy, 1);
                chk($sformatf("v%0d_req_k%0d", id, k), dmem_req, exp_req);
                if (dmem_req) begin
                    chk($sformatf("v%0d_daddr_k%0d", id, k), dmem_addr, v.e_daddr);
                    chk($sformatf("v%0d_be_k%0d", id, k), dmem_be, v.e_be);
                    chk($sformatf("v%0d_dwdata_k%0d", id, k), dmem_wdata, v.e_dwdata);
                    chk($sformatf("v%0d_we_k%0d", id, k), dmem_we, v.wr);
                    if (reqs == v.ack_dly) begin
                        dmem_ack = 1'b1;
                        dmem_rdata = v.rdata;
                    end
                    reqs++;
                end
                @(negedge clk);
                k++;
            end
        end
        dmem_ack = 1'b0;
        chk($sformatf("v%0d_done_seen", id), done, 1);
        chk($sformatf("v%0d_done_cycle", id), k, exp_k);
        chk($sformatf("v%0d_req_cycles", id), reqs, exp_req ? v.ack_dly + 1 : 0);
        chk($sformatf("v%0d_rdata", id), lsu_rdata, v.e_rdata);
        chk($sformatf("v%0d_mis", id), lsu_misaligned, v.e_mis);
        chk($sformatf("v%0d_berr", id), lsu_bus_err, v.e_berr);
        chk($sformatf("v%0d_req_in_done", id), dmem_req, 0);
        chk($sformatf("v%0d_busy_in_done", id), lsu_busy, 1);
        @(negedge clk);
        chk($sformatf("v%0d_idle_done", id), lsu_done, 0);
        chk($sformatf("v%0d_idle_busy", id), lsu_busy, 0);
        chk($sformatf("v%0d_idle_rdata", id), lsu_rdata, 0);
        chk($sformatf("v%0d_idle_flags", id), {lsu_misaligned, lsu_bus_err}, 0);
    endtask

    initial begin
        int k;
        int reqs;

        //                rd  wr  f3      addr          wdata         rdata        dly daddr         be       dwdata        rdata        mis  berr
        vecs[0]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'hFFFF_FFFF, 0, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 32'h0,         1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0,         32'h1234_80FF, 0, 32'h0000_2000, 4'b0010, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0,         32'h1234_80FF, 0, 32'h0000_2000, 4'b0010, 32'h0,         32'h0000_0080, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0,         32'hBEEF_0000, 5, 32'h0000_4000, 4'b1100, 32'h0,         32'h0000_BEEF, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_2006, 32'h1111_ABCD, 32'hFFFF_FFFF, 1, 32'h0000_2004, 4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0,         32'h0000_8001, 2, 32'h0000_0000, 4'b0011, 32'h0,         32'hFFFF_8001, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 0, 32'h0000_0008, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 3'b001, 32'h0000_0001, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 3'b000, 32'h0000_0003, 32'h0,         32'h7F00_0000, 0, 32'h0000_0000, 4'b1000, 32'h0,         32'h0000_007F, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 3'b000, 32'h0000_0005, 32'h0000_00A5, 32'hFFFF_FFFF, 3, 32'h0000_0004, 4'b0010, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 3'b100, 32'h0000_0006, 32'h0,         32'h00C3_0000, 0, 32'h0000_0004, 4'b0100, 32'h0,         32'h0000_00C3, 1'b0, 1'b0);

        rst_n = 1'b0; ex_valid = 1'b0; ex_valid_t = 1'b0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_funct3 = 3'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
        dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_main("reset");
        chk("reset_t_ctl", {24'b0, t_busy, t_done, t_mis, t_berr, t_req, t_we, 2'b0} | {28'b0, t_be}, 32'h0);
        chk("reset_t_data", t_rdata | t_addr | t_wdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: LW on the TIMEOUT=4 instance, no ack until after the bus error.
        @(negedge clk);
        ex_valid_t = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h0000_0020;
        @(negedge clk);
        ex_valid_t = 1'b0; ex_mem_read = 1'b0;
        k = 1; reqs = 0;
        while (!t_done && k <= 20) begin
            chk($sformatf("to_busy_k%0d", k), t_busy, 1);
            if (t_req) reqs++;
            @(negedge clk);
            k++;
        end
        chk("to_done_seen", t_done, 1);
        chk("to_req_cycles", reqs, 4);
        chk("to_done_cycle", k, 5);
        chk("to_berr", t_berr, 1);
        chk("to_mis", t_mis, 0);
        chk("to_rdata", t_rdata, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("to_late_done_%0d", j), t_done, 0);
            chk($sformatf("to_late_busy_%0d", j), t_busy, 0);
            chk($sformatf("to_late_req_%0d", j), t_req, 0);
            chk($sformatf("main_stray_ack_done_%0d", j), lsu_done, 0);
        end
        dmem_ack = 1'b0;

        // Reset while a load is waiting in REQ.
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_0040;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        chk("rst_pre_req0", dmem_req, 1);
        @(negedge clk);
        chk("rst_pre_req1", dmem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_main("rst_mid");
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("rst_no_done_%0d", j), lsu_done, 0);
            chk($sformatf("rst_no_req_%0d", j), dmem_req, 0);
        end
        dmem_ack = 1'b0;
        run_vec(100, mk(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 0,
                        32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
